// File: rtl/out_port_pwm_pkg.sv
// out_port_pwm_pkg: shared constants, FSM state type and the duty fade helper for the PIO PWM dimmer
package out_port_pwm_pkg;
  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] PWM_TOP = 8'd254;
  typedef enum logic {ST_IDLE, ST_RUN} pwm_state_t;
  function automatic logic [DUTY_W-1:0] fade_step(input logic [DUTY_W-1:0] cur, input logic [DUTY_W-1:0] tgt);
    return cur < tgt ? cur + 1'b1 : cur > tgt ? cur - 1'b1 : cur;
  endfunction
endpackage

// File: rtl/out_port_pwm_dimmer_prescaler.sv
// pwm_prescaler: divides clk by CLK_DIV into a one-cycle step strobe; counter held at 0 while run is low
module pwm_prescaler #(
  parameter int CLK_DIV = 195,
  parameter int DIV_W   = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic step
);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);
  logic [DIV_W-1:0] r_div;
  always_ff @(posedge clk)
    if (!reset_n || !run) r_div <= '0;
    else r_div <= r_div == LAST ? '0 : r_div + 1'b1;
  assign step = run && r_div == LAST;
endmodule

// File: rtl/out_port_pwm_dimmer.sv
// out_port_pwm_dimmer: PWM pin driven from the PIO byte, duty reloaded at period boundaries.
// Define OUT_PORT_PWM_FADE_EN to slew the applied duty by one LSB per period instead of jumping.
module out_port_pwm_dimmer
  import out_port_pwm_pkg::*;
#(
  parameter int CLK_DIV = 195,
  parameter int DIV_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              enable,
  output logic              pwm_out,
  output logic              period_tick,
  output logic [DUTY_W-1:0] duty_active
);
  pwm_state_t r_state;
  logic [DUTY_W-1:0] r_cnt;
  logic w_run, w_step, w_wrap;
  logic [DUTY_W-1:0] w_reload;
  // gating with enable clears the prescaler on the same edge that leaves RUN
  assign w_run = r_state == ST_RUN && enable;
  pwm_prescaler #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) u_pre (
    .clk(clk), .reset_n(reset_n), .run(w_run), .step(w_step)
  );
  assign w_wrap = w_step && r_cnt == PWM_TOP;
`ifdef OUT_PORT_PWM_FADE_EN
  assign w_reload = fade_step(duty_active, duty_in);
`else
  assign w_reload = duty_in;
`endif
  always_ff @(posedge clk)
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      duty_active <= '0;
      pwm_out     <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      r_state     <= enable ? ST_RUN : ST_IDLE;
      r_cnt       <= !w_run || w_wrap ? '0 : w_step ? r_cnt + 1'b1 : r_cnt;
      period_tick <= w_wrap;
      pwm_out     <= r_state == ST_RUN && r_cnt < duty_active;
      duty_active <= r_state == ST_IDLE ? duty_in : w_wrap ? w_reload : duty_active;
    end
endmodule

// File: tb/tb_out_port_pwm_dimmer.sv
// tb_out_port_pwm_dimmer: directed and randomized checks of the PWM dimmer against a time-based model
module tb_out_port_pwm_dimmer;
  localparam int DIV = 4;
  localparam int PER = 255 * DIV;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [7:0] din = 8'h00;
  logic pwm_out, period_tick;
  logic [7:0] duty_active;
  int tests = 0;
  int fails = 0;
  bit m_run = 1'b0;
  int m_k = 0;
  logic [7:0] m_duty = 8'h00;
  logic m_pwm = 1'b0;
  logic m_tick = 1'b0;
  int n, h, hi, nt;

  out_port_pwm_dimmer #(.CLK_DIV(DIV), .DIV_W(16)) dut (
    .clk(clk), .reset_n(rst_n), .duty_in(din), .enable(en),
    .pwm_out(pwm_out), .period_tick(period_tick), .duty_active(duty_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // model: m_k counts cycles spent in RUN, the period position is m_k mod PER
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) begin
      m_run = 0; m_k = 0; m_duty = 0; m_pwm = 0; m_tick = 0;
    end else if (!m_run) begin
      m_pwm = 0; m_tick = 0; m_duty = din; m_run = en; m_k = 0;
    end else begin
      m_pwm = ((m_k % PER) / DIV) < int'(m_duty);
      m_tick = en && (m_k % PER == PER - 1);
`ifdef OUT_PORT_PWM_FADE_EN
      if (m_tick) m_duty = din > m_duty ? m_duty + 8'd1 : din < m_duty ? m_duty - 8'd1 : m_duty;
`else
      if (m_tick) m_duty = din;
`endif
      if (en) m_k++;
      else begin m_run = 0; m_k = 0; end
    end
    @(negedge clk);
    chk("pwm_out", int'(pwm_out), int'(m_pwm));
    chk("period_tick", int'(period_tick), int'(m_tick));
    chk("duty_active", int'(duty_active), int'(m_duty));
  endtask

  // from the current cycle, run to the next tick; cnt = cycles spent, highs = pwm highs before it
  task automatic next_tick(output int cnt, output int highs);
    bit seen = 0;
    highs = int'(pwm_out);
    cnt = 0;
    while (!seen && cnt < 3 * PER) begin
      cyc();
      cnt++;
      if (period_tick) seen = 1;
      else highs += int'(pwm_out);
    end
    if (!seen) chk("tick_timeout", cnt, -1);
  endtask

  initial begin
    rst_n = 0; en = 1; din = 8'hAA;
    repeat (4) cyc();
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_tick", int'(period_tick), 0);
    chk("reset_duty", int'(duty_active), 0);
`ifndef OUT_PORT_PWM_FADE_EN
    din = 8'h00; rst_n = 1;
    next_tick(n, h); hi = h;
    next_tick(n, h); hi += h;
    chk("zero_duty_highs", hi, 0);
    din = 8'hFF;
    next_tick(n, h);
    next_tick(n, h);
    next_tick(n, h);
    chk("full_duty_highs", h, PER);
    din = 8'h40;
    next_tick(n, h);
    next_tick(n, h);
    next_tick(n, h);
    chk("q_duty_highs", h, 256);
    chk("q_tick_spacing", n, PER);
    hi = int'(pwm_out);
    repeat (39) begin cyc(); hi += int'(pwm_out); end
    cyc();
    din = 8'hC0;
    next_tick(n, h);
    chk("midchange_highs", hi + h, 256);
    chk("midchange_spacing", 40 + n, PER);
    chk("reload_duty", int'(duty_active), 8'hC0);
    next_tick(n, h);
    chk("c0_duty_highs", h, 768);
    repeat (80) cyc();
    en = 0;
    cyc(); cyc();
    chk("disable_pwm", int'(pwm_out), 0);
    chk("idle_tracks", int'(duty_active), 8'hC0);
    repeat (5) cyc();
    en = 1; din = 8'h40;
    cyc();
    chk("enable_load", int'(duty_active), 8'h40);
    next_tick(n, h);
    chk("reenable_first_tick", n, PER);
`else
    rst_n = 1; en = 0; din = 8'h00;
    cyc();
    en = 1;
    cyc();
    din = 8'h03;
    for (int i = 1; i <= 3; i++) begin
      next_tick(n, h);
      chk("fade_up", int'(duty_active), i);
    end
    next_tick(n, h);
    chk("fade_steady", int'(duty_active), 3);
    din = 8'h01;
    next_tick(n, h);
    chk("fade_down1", int'(duty_active), 2);
    next_tick(n, h);
    chk("fade_down2", int'(duty_active), 1);
`endif
    rst_n = 1; en = 1;
    nt = 0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 63) == 0) din = 8'($urandom);
      if ($urandom_range(0, 1499) == 0) en = ~en;
      rst_n = $urandom_range(0, 2499) != 0;
      cyc();
      nt += int'(period_tick);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
